// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle multiply hold,
// branch flush and memory-wait freeze, with a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_regA,
  input  logic [4:0]  id_regB,
  input  logic        id_usesA,
  input  logic        id_usesB,
  input  logic        id_is_mult,
  input  logic        jump_or_branch,
  input  logic        ex_is_load,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_wait,
  output logic        reg_lock_if,
  output logic        reg_lock_id,
  output logic        reg_lock_ex,
  output logic        reg_lock_mem,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        flush_if,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StMult = 2'b01
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use;

  assign load_use = ex_is_load & ex_reg_write & (ex_write_reg != 5'd0) & id_valid &
                    ((id_usesA & (id_regA == ex_write_reg)) |
                     (id_usesB & (id_regB == ex_write_reg)));

  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    reg_lock_if  = 1'b0;
    reg_lock_id  = 1'b0;
    reg_lock_ex  = 1'b0;
    reg_lock_mem = 1'b0;
    bubble_ex    = 1'b0;
    bubble_mem   = 1'b0;
    flush_if     = 1'b0;

    if (mem_wait) begin
      // Full freeze: nothing advances, state and counter hold.
      reg_lock_if  = 1'b1;
      reg_lock_id  = 1'b1;
      reg_lock_ex  = 1'b1;
      reg_lock_mem = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            reg_lock_if = 1'b1;
            reg_lock_id = 1'b1;
            bubble_ex   = 1'b1;
          end else if (id_valid && id_is_mult) begin
            state_d = StMult;
            mcnt_d  = 4'(MULT_CYCLES - 2);
          end else if (id_valid && jump_or_branch) begin
            flush_if = 1'b1;
          end
        end
        StMult: begin
          reg_lock_if = 1'b1;
          reg_lock_id = 1'b1;
          reg_lock_ex = 1'b1;
          bubble_mem  = 1'b1;
          if (mcnt_q == 4'd0) begin
            state_d = StRun;
          end else begin
            mcnt_d = mcnt_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end

    // Outputs are forced low for the whole reset, not just after the next edge.
    if (!rst_n) begin
      reg_lock_if  = 1'b0;
      reg_lock_id  = 1'b0;
      reg_lock_ex  = 1'b0;
      reg_lock_mem = 1'b0;
      bubble_ex    = 1'b0;
      bubble_mem   = 1'b0;
      flush_if     = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (reg_lock_if && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      mcnt_q  <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      stall_q <= stall_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MULT_CYCLES = 4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_usesA, id_usesB, id_is_mult, jump_or_branch;
  logic [4:0]  id_regA, id_regB, ex_write_reg;
  logic        ex_is_load, ex_reg_write, mem_wait;
  logic        reg_lock_if, reg_lock_id, reg_lock_ex, reg_lock_mem;
  logic        bubble_ex, bubble_mem, flush_if;
  logic [1:0]  state;
  logic [15:0] stall_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_stall = 0;
  int unsigned mult_cycles_seen;

  pipeline_hazard_ctrl #(.MULT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_regA        (id_regA),
    .id_regB        (id_regB),
    .id_usesA       (id_usesA),
    .id_usesB       (id_usesB),
    .id_is_mult     (id_is_mult),
    .jump_or_branch (jump_or_branch),
    .ex_is_load     (ex_is_load),
    .ex_reg_write   (ex_reg_write),
    .ex_write_reg   (ex_write_reg),
    .mem_wait       (mem_wait),
    .reg_lock_if    (reg_lock_if),
    .reg_lock_id    (reg_lock_id),
    .reg_lock_ex    (reg_lock_ex),
    .reg_lock_mem   (reg_lock_mem),
    .bubble_ex      (bubble_ex),
    .bubble_mem     (bubble_mem),
    .flush_if       (flush_if),
    .state          (state),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    id_valid = 1'b0; id_usesA = 1'b0; id_usesB = 1'b0; id_is_mult = 1'b0;
    jump_or_branch = 1'b0; id_regA = 5'd0; id_regB = 5'd0;
    ex_is_load = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0; mem_wait = 1'b0;
  endtask

  // Advance one clock; leaves time at 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs {lock_if, lock_id, lock_ex, lock_mem, bubble_ex, bubble_mem, flush_if}.
  function automatic logic [31:0] outs();
    return {25'd0, reg_lock_if, reg_lock_id, reg_lock_ex, reg_lock_mem,
            bubble_ex, bubble_mem, flush_if};
  endfunction

  initial begin
    clear_in();
    rst_n = 1'b0;
    mem_wait = 1'b1;
    #2;
    check("reset_outs_held_low", outs(), 32'h00);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_stall", {16'd0, stall_count}, 32'd0);
    mem_wait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_outs", outs(), 32'h00);

    // Load-use on regA
    id_valid = 1'b1; id_usesA = 1'b1; id_regA = 5'd5;
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd5;
    #1;
    check("load_use_a_outs", outs(), 32'b1100100);
    step();
    exp_stall++;
    clear_in();
    #1;
    check("load_use_a_state", {30'd0, state}, 32'd0);
    check("load_use_released", outs(), 32'h00);
    check("load_use_stall", {16'd0, stall_count}, exp_stall);

    // Load-use on regB; regA matching but unused must not lock
    id_valid = 1'b1; id_usesA = 1'b0; id_regA = 5'd7; id_usesB = 1'b1; id_regB = 5'd9;
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd7;
    #1;
    check("unused_a_no_lock", outs(), 32'h00);
    ex_write_reg = 5'd9;
    #1;
    check("load_use_b_outs", outs(), 32'b1100100);
    step();
    exp_stall++;
    clear_in();

    // Register 0 exemption, then branch flush
    id_valid = 1'b1; id_usesA = 1'b1; id_regA = 5'd0;
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd0;
    #1;
    check("r0_no_lock", outs(), 32'h00);
    jump_or_branch = 1'b1;
    #1;
    check("branch_flush", outs(), 32'b0000001);
    step();
    jump_or_branch = 1'b0;
    #1;
    check("flush_one_cycle", outs(), 32'h00);
    // Load-use beats flush
    jump_or_branch = 1'b1; ex_write_reg = 5'd3; id_regA = 5'd3;
    #1;
    check("load_use_over_flush", outs(), 32'b1100100);
    step();
    exp_stall++;
    clear_in();

    // Multiply timing: 3 cycles in MULT, flush ignored there
    id_valid = 1'b1; id_is_mult = 1'b1;
    #1;
    check("mult_entry_no_lock", outs(), 32'h00);
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      jump_or_branch = 1'b1; id_valid = 1'b1;
      #1;
      check($sformatf("mult_state_c%0d", i), {30'd0, state}, 32'd1);
      check($sformatf("mult_outs_c%0d", i), outs(), 32'b1110010);
      step();
      exp_stall++;
    end
    clear_in();
    #1;
    check("mult_exit_state", {30'd0, state}, 32'd0);
    check("mult_exit_outs", outs(), 32'h00);
    check("mult_stall", {16'd0, stall_count}, exp_stall);

    // mem_wait in RUN overrides load-use
    id_valid = 1'b1; id_usesA = 1'b1; id_regA = 5'd4;
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd4; mem_wait = 1'b1;
    #1;
    check("mem_wait_run_outs", outs(), 32'b1111000);
    step();
    exp_stall++;
    clear_in();

    // mem_wait for 2 cycles mid-MULT stretches MULT to 5 cycles
    id_valid = 1'b1; id_is_mult = 1'b1;
    step();
    clear_in();
    mult_cycles_seen = 0;
    for (int i = 0; i < 12; i++) begin
      mem_wait = (mult_cycles_seen == 1 || mult_cycles_seen == 2);
      #1;
      if (state == 2'b01) begin
        if (mem_wait) check($sformatf("mult_freeze_outs_%0d", i), outs(), 32'b1111000);
        mult_cycles_seen++;
        exp_stall++;
      end
      step();
    end
    clear_in();
    check("mult_stretched_len", mult_cycles_seen, 32'd5);
    check("mult_stretched_stall", {16'd0, stall_count}, exp_stall);

    // Asynchronous reset mid-MULT
    id_valid = 1'b1; id_is_mult = 1'b1;
    step();
    clear_in();
    #1;
    check("pre_reset_in_mult", {30'd0, state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", {30'd0, state}, 32'd0);
    check("async_reset_outs", outs(), 32'h00);
    check("async_reset_stall", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_state", {30'd0, state}, 32'd0);
    check("post_reset_stall", {16'd0, stall_count}, 32'd0);

    // Saturation under sustained mem_wait
    mem_wait = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("stall_saturated", {16'd0, stall_count}, 32'h0000FFFF);
    step();
    check("stall_no_wrap", {16'd0, stall_count}, 32'h0000FFFF);
    mem_wait = 1'b0;
    step();
    check("stall_holds_after", {16'd0, stall_count}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
